// File: rtl/multdiv_controller.sv
// Sequencer for the multi-cycle MUL/DIV unit in X stage: latch operands, pulse start,
// stall until ready, then emit one writeback beat. Optional WAIT timeout: MULTDIV_TIMEOUT_EN.
module multdiv_controller #(
  parameter int DATA_W         = 32,
  parameter int REG_W          = 5,
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_x_valid,
  input  logic              i_is_mul,
  input  logic              i_is_div,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_op_a,
  input  logic [DATA_W-1:0] i_op_b,
  input  logic [REG_W-1:0]  i_rd_in,
  output logic              o_ctrl_MULT,
  output logic              o_ctrl_DIV,
  output logic [DATA_W-1:0] o_md_op_a,
  output logic [DATA_W-1:0] o_md_op_b,
  input  logic [DATA_W-1:0] i_md_result,
  input  logic              i_md_exception,
  input  logic              i_md_ready,
  output logic              o_stall,
  output logic              o_busy,
  output logic              o_wb_valid,
  output logic [REG_W-1:0]  o_wb_rd,
  output logic [DATA_W-1:0] o_wb_data,
  output logic              o_wb_exception
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [REG_W-1:0]  RSTATUS = REG_W'(30);
  localparam logic [DATA_W-1:0] EXC_MUL = DATA_W'(4);
  localparam logic [DATA_W-1:0] EXC_DIV = DATA_W'(5);

  logic [1:0]        r_state;
  logic              r_is_mul;
  logic [DATA_W-1:0] r_op_a, r_op_b;
  logic [REG_W-1:0]  r_rd;
  logic [REG_W-1:0]  r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_wb_exc;

  logic       w_start;
  logic [1:0] w_state_nxt;
  logic       w_capture;
  logic       w_cap_exc;

  assign w_start = i_x_valid & (i_is_mul | i_is_div) & ~i_flush;

`ifdef MULTDIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_timeout;

  // Counter reads 0 on the first WAIT cycle, so the last allowed cycle is TIMEOUT_CYCLES-1.
  assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset || r_state != S_WAIT) r_wait_cnt <= '0;
    else                              r_wait_cnt <= r_wait_cnt + 1'b1;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_cap_exc   = i_md_exception;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_START;
      S_START: w_state_nxt = i_flush ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (i_flush) begin
          w_state_nxt = S_IDLE;
        end else if (i_md_ready) begin
          w_state_nxt = S_DONE;
          w_capture   = 1'b1;
        end
`ifdef MULTDIV_TIMEOUT_EN
        else if (w_timeout) begin
          w_state_nxt = S_DONE;
          w_capture   = 1'b1;
          w_cap_exc   = 1'b1;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_is_mul  <= 1'b0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_rd      <= '0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
      r_wb_exc  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_start) begin
        r_is_mul <= i_is_mul;
        r_op_a   <= i_op_a;
        r_op_b   <= i_op_b;
        r_rd     <= i_rd_in;
      end
      // Writeback fields are only touched on capture so they hold between beats.
      if (w_capture) begin
        r_wb_rd   <= w_cap_exc ? RSTATUS : r_rd;
        r_wb_data <= w_cap_exc ? (r_is_mul ? EXC_MUL : EXC_DIV) : i_md_result;
        r_wb_exc  <= w_cap_exc;
      end
    end
  end

  assign o_ctrl_MULT    = (r_state == S_START) &  r_is_mul & ~i_flush;
  assign o_ctrl_DIV     = (r_state == S_START) & ~r_is_mul & ~i_flush;
  assign o_md_op_a      = r_op_a;
  assign o_md_op_b      = r_op_b;
  assign o_stall        = ((r_state == S_IDLE) & w_start) | (r_state == S_START) | (r_state == S_WAIT);
  assign o_busy         = (r_state != S_IDLE);
  assign o_wb_valid     = (r_state == S_DONE);
  assign o_wb_rd        = r_wb_rd;
  assign o_wb_data      = r_wb_data;
  assign o_wb_exception = r_wb_exc;

endmodule

// File: tb/tb_multdiv_controller.sv
// Bench for multdiv_controller: vector table plus hand sequences for flush, reset and timeout.
module tb_multdiv_controller;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          x_valid, is_mul, is_div, flush;
  logic [DW-1:0] op_a, op_b, md_result;
  logic [RW-1:0] rd_in;
  logic          md_exception, md_ready;
  logic          ctrl_MULT, ctrl_DIV, stall, busy, wb_valid, wb_exc;
  logic [DW-1:0] md_op_a, md_op_b, wb_data;
  logic [RW-1:0] wb_rd;

  always #5 clk = ~clk;

  multdiv_controller #(.DATA_W(DW), .REG_W(RW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clock(clk), .i_reset(rst), .i_x_valid(x_valid), .i_is_mul(is_mul), .i_is_div(is_div),
    .i_flush(flush), .i_op_a(op_a), .i_op_b(op_b), .i_rd_in(rd_in),
    .o_ctrl_MULT(ctrl_MULT), .o_ctrl_DIV(ctrl_DIV), .o_md_op_a(md_op_a), .o_md_op_b(md_op_b),
    .i_md_result(md_result), .i_md_exception(md_exception), .i_md_ready(md_ready),
    .o_stall(stall), .o_busy(busy), .o_wb_valid(wb_valid), .o_wb_rd(wb_rd),
    .o_wb_data(wb_data), .o_wb_exception(wb_exc)
  );

  typedef struct {
    logic          mul, div;
    logic [DW-1:0] a, b;
    logic [RW-1:0] rd;
    int            lat;        // WAIT cycles before the md_ready cycle
    logic          exc;        // unit reports exception
    logic          rdy_start;  // spurious md_ready during START
    logic          poke_done;  // flush + new MUL request during DONE
    logic [RW-1:0] e_rd;
    logic [DW-1:0] e_data;
    logic          e_exc;
  } vec_t;

  typedef struct packed {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
    logic          exc;
  } wb_t;

  wb_t  sb[$];
  wb_t  mon_e;
  vec_t vecs[$];
  int   n_cmp = 0, n_err = 0, n_mul = 0, n_div = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic mul, logic div, logic [DW-1:0] a, logic [DW-1:0] b,
                              logic [RW-1:0] rd, int lat, logic exc, logic rs, logic pk,
                              logic [RW-1:0] erd, logic [DW-1:0] ed, logic ee);
    vec_t v;
    v.mul = mul; v.div = div; v.a = a; v.b = b; v.rd = rd; v.lat = lat; v.exc = exc;
    v.rdy_start = rs; v.poke_done = pk; v.e_rd = erd; v.e_data = ed; v.e_exc = ee;
    return v;
  endfunction

  // Scoreboard consumer plus start-pulse counters
  always @(negedge clk) begin
    if (!rst) begin
      if (ctrl_MULT) n_mul++;
      if (ctrl_DIV)  n_div++;
      if (wb_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL wb_unexpected: got wb_valid=1 (rd=%0d) expected 0", wb_rd);
        end else begin
          mon_e = sb.pop_front();
          chk("wb_rd",  32'(wb_rd), 32'(mon_e.rd));
          chk("wb_data", wb_data,   mon_e.data);
          chk("wb_exc", 32'(wb_exc), 32'(mon_e.exc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_in();
    x_valid = 0; is_mul = 0; is_div = 0; flush = 0;
    op_a = '1; op_b = '1; rd_in = '1;
  endtask

  task automatic issue(input logic m, input logic d, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [RW-1:0] r);
    x_valid = 1; is_mul = m; is_div = d; op_a = a; op_b = b; rd_in = r;
  endtask

  task automatic run_vec(input vec_t v);
    int m0, d0;
    sb.push_back('{v.e_rd, v.e_data, v.e_exc});
    m0 = n_mul; d0 = n_div;
    issue(v.mul, v.div, v.a, v.b, v.rd);
    @(negedge clk); chk("stall_issue", 32'(stall), 1);
    tick(); clear_in();
    if (v.rdy_start) begin md_ready = 1; md_result = 32'hDEAD_BEEF; md_exception = 1; end
    @(negedge clk);
    chk("md_op_a", md_op_a, v.a);
    chk("md_op_b", md_op_b, v.b);
    tick();
    for (int c = 0; c <= v.lat; c++) begin
      if (c == v.lat) begin
        md_ready = 1; md_exception = v.exc;
        md_result = v.mul ? v.a * v.b : (v.b == 0 ? '0 : v.a / v.b);
      end else begin
        md_ready = 0; md_exception = 0;
      end
      @(negedge clk);
      chk("stall_wait", 32'(stall), 1);
      chk("wb_early", 32'(wb_valid), 0);
      tick();
    end
    md_ready = 0; md_exception = 0; md_result = 32'h0BAD_0BAD;
    if (v.poke_done) begin flush = 1; issue(1'b1, 1'b0, 32'd1, 32'd1, 5'd2); end
    @(negedge clk);
    chk("wb_valid_done", 32'(wb_valid), 1);
    chk("stall_done", 32'(stall), 0);
    tick(); clear_in();
    @(negedge clk);
    chk("wb_one_beat", 32'(wb_valid), 0);
    chk("busy_after", 32'(busy), 0);
    chk("sb_drained", 32'(sb.size()), 0);
    chk("wb_hold", wb_data, v.e_data);
    chk("pulse_mul", 32'(n_mul - m0), v.mul ? 1 : 0);
    chk("pulse_div", 32'(n_div - d0), (!v.mul && v.div) ? 1 : 0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int m0, d0, k;
    rst = 1; clear_in(); md_ready = 0; md_exception = 0; md_result = '0;
    tick(); tick(); tick();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_md_op_a", md_op_a, 0);
    chk("rst_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 0);
    tick(); rst = 0;
    tick();

    //                 mul div a             b             rd  lat exc rs pk  e_rd e_data        e_exc
    vecs.push_back(mk(1, 0, 32'd6,        32'd7,        3,  16, 0, 0, 0,  3,  32'd42,       0));
    vecs.push_back(mk(0, 1, 32'd100,      32'd0,        5,  3,  1, 0, 0,  30, 32'd5,        1));
    vecs.push_back(mk(1, 1, 32'd3,        32'd5,        7,  2,  0, 0, 0,  7,  32'd15,       0));
    vecs.push_back(mk(0, 1, 32'd100,      32'd7,        9,  0,  0, 0, 0,  9,  32'd14,       0));
    vecs.push_back(mk(1, 0, 32'h1_0000,   32'h1_0000,   11, 1,  1, 0, 0,  30, 32'd4,        1));
    vecs.push_back(mk(1, 0, 32'hFFFF,     32'hFFFF,     0,  2,  0, 0, 0,  0,  32'hFFFE_0001, 0));
    vecs.push_back(mk(0, 1, 32'd1000,     32'd10,       31, 4,  0, 1, 0,  31, 32'd100,      0));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFF, 32'd2,       1,  6,  0, 0, 1,  1,  32'h7FFF_FFFF, 0));
`ifdef MULTDIV_TIMEOUT_EN
    vecs.push_back(mk(1, 0, 32'd12,       32'd12,       8,  TO-1, 0, 0, 0, 8, 32'd144,      0));
`else
    vecs.push_back(mk(1, 0, 32'd12,       32'd12,       8,  60, 0, 0, 0,  8,  32'd144,      0));
`endif
    foreach (vecs[i]) run_vec(vecs[i]);

    // Flush concurrent with md_ready in WAIT: dropped, late ready ignored
    m0 = n_mul;
    issue(1, 0, 32'd2, 32'd2, 5'd4);
    tick(); clear_in();
    tick(); tick();
    flush = 1; md_ready = 1; md_result = 32'd4;
    tick(); flush = 0;
    @(negedge clk);
    chk("flushw_busy", 32'(busy), 0);
    chk("flushw_stall", 32'(stall), 0);
    for (int i = 0; i < 3; i++) begin tick(); @(negedge clk); end
    chk("flushw_idle", 32'(busy), 0);
    chk("flushw_pulses", 32'(n_mul - m0), 1);
    md_ready = 0;
    tick();

    // Flush in START: no start pulse
    d0 = n_div;
    issue(0, 1, 32'd9, 32'd3, 5'd6);
    tick(); clear_in(); flush = 1;
    @(negedge clk);
    chk("flushs_ctrl_div", 32'(ctrl_DIV), 0);
    tick(); flush = 0;
    @(negedge clk);
    chk("flushs_busy", 32'(busy), 0);
    chk("flushs_pulses", 32'(n_div - d0), 0);
    tick();

    // Reset in WAIT clears everything, no further pulses
    issue(1, 0, 32'd5, 32'd5, 5'd10);
    tick(); clear_in();
    tick(); tick();
    rst = 1;
    tick(); rst = 0;
    m0 = n_mul; d0 = n_div;
    @(negedge clk);
    chk("rstw_stall", 32'(stall), 0);
    chk("rstw_busy", 32'(busy), 0);
    chk("rstw_wb_valid", 32'(wb_valid), 0);
    chk("rstw_wb_rd", 32'(wb_rd), 0);
    chk("rstw_md_op_a", md_op_a, 0);
    md_ready = 1; md_result = 32'd25;
    for (int i = 0; i < 4; i++) begin tick(); @(negedge clk); end
    chk("rstw_pulses", 32'(n_mul - m0 + n_div - d0), 0);
    chk("rstw_idle", 32'(busy), 0);
    md_ready = 0;
    tick();

`ifdef MULTDIV_TIMEOUT_EN
    // Unit never answers: forced exception after TO WAIT cycles
    sb.push_back('{5'd30, 32'd4, 1'b1});
    issue(1, 0, 32'd9, 32'd9, 5'd12);
    tick(); clear_in();
    tick();
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      if (wb_valid) break;
      k++;
      tick();
    end
    chk("timeout_cycles", 32'(k), 32'(TO));
    tick();
    @(negedge clk);
    chk("timeout_idle", 32'(busy), 0);
    chk("timeout_sb", 32'(sb.size()), 0);
    tick();
`else
    k = 0;
    chk("no_timeout_busy", 32'(busy + k), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
